sdr_port_arbiter: RTL and testbench

Shares a single SDRAM channel among N requesters (CPU ROM cache, BG tile fetch, sprite fetch, audio sample fetch) on the clk_sys side of the SDRAM controller. It selects requesters by fixed priority with anti-starvation aging, latches the winning address, and runs the downstream level/ready handshake. It returns captured data to the winner with a one-cycle ready pulse. It sits between the video/sound/CPU fetch units and the single SDRAM port.

---
 rtl/sdr_port_arbiter.sv | 117 +++++++++++
 tb/tb_sdr_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_port_arbiter.sv
// Fixed-priority SDRAM port arbiter with anti-starvation aging.
// One access is in flight at a time: latch the winner, hold mem_req until mem_rdy, then pulse rdy.
//
// state | meaning
// IDLE  | arbitrate among pending requesters, latch winner and address
// ISSUE | mem_req high, waiting for mem_rdy; capture mem_din on completion
// DONE  | rdy[grant] pulses for one cycle, then back to IDLE
module sdr_port_arbiter #(
    parameter int N            = 4,
    parameter int AW           = 25,
    parameter int DW           = 64,
    parameter int STARVE_LIMIT = 64,
    localparam int GW          = (N > 1) ? $clog2(N) : 1,
    localparam int AGW         = $clog2(STARVE_LIMIT + 1)
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] req_addr,
    output logic [N-1:0]    rdy,
    output logic [DW-1:0]   dout,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_req,
    input  logic [DW-1:0]   mem_din,
    input  logic            mem_rdy,
    output logic            busy,
    output logic [GW-1:0]   grant
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [GW-1:0]    r_grant;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_dout;
    logic [AGW-1:0]   r_age [N];
    logic [GW-1:0]    w_win;
    logic             w_starved;
    logic             w_latch;

    // Starved requesters (still asking) pre-empt base priority; lowest index wins in each class.
    always_comb begin
        w_win     = '0;
        w_starved = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && r_age[i] == AGW'(STARVE_LIMIT)) begin
                w_win     = GW'(i);
                w_starved = 1'b1;
            end
        end
        if (!w_starved) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) w_win = GW'(i);
            end
        end
    end

    assign w_latch = (r_state == S_IDLE) && (|req);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (|req)   w_next = S_ISSUE;
            S_ISSUE: if (mem_rdy) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != S_IDLE);
        mem_req = (r_state == S_ISSUE);
        rdy     = '0;
        if (r_state == S_DONE) rdy[r_grant] = 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_grant    <= '0;
            r_mem_addr <= '0;
            r_dout     <= '0;
        end else begin
            if (w_latch) begin
                r_grant    <= w_win;
                r_mem_addr <= req_addr[int'(w_win)*AW +: AW];
            end
            if (r_state == S_ISSUE && mem_rdy) r_dout <= mem_din;
        end
    end

    // Ages freeze while their own access is in ISSUE/DONE and saturate at the limit.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) r_age[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || (w_latch && w_win == GW'(i)))
                    r_age[i] <= '0;
                else if (r_state != S_IDLE && r_grant == GW'(i))
                    r_age[i] <= r_age[i];
                else if (r_age[i] != AGW'(STARVE_LIMIT))
                    r_age[i] <= r_age[i] + 1'b1;
            end
        end
    end

    assign grant    = r_grant;
    assign mem_addr = r_mem_addr;
    assign dout     = r_dout;

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// Directed bench for sdr_port_arbiter: single access, spurious mem_rdy, back-to-back,
// mid-ISSUE drop, async reset in ISSUE, and full contention with aging.
module tb_sdr_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 25;
    localparam int DW = 64;

    logic            clk_sys = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    rdy;
    logic [DW-1:0]   dout;
    logic [AW-1:0]   mem_addr;
    logic            mem_req;
    logic [DW-1:0]   mem_din;
    logic            mem_rdy;
    logic            busy;
    logic [1:0]      grant;

    logic auto_rdy = 1'b0;
    logic spur_rdy = 1'b0;
    int   rsp_delay = 1;
    int   rsp_cnt = 0;
    int   cyc = 0;
    int   mreq_total = 0;
    logic [N-1:0] rdy_log [$];
    int   rdy_cyc [$];
    int   n_checks = 0;
    int   n_fail = 0;

    assign mem_rdy = auto_rdy | spur_rdy;

    always #5 clk_sys = ~clk_sys;

    sdr_port_arbiter #(.N(N), .AW(AW), .DW(DW), .STARVE_LIMIT(64)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .req      (req),
        .req_addr (req_addr),
        .rdy      (rdy),
        .dout     (dout),
        .mem_addr (mem_addr),
        .mem_req  (mem_req),
        .mem_din  (mem_din),
        .mem_rdy  (mem_rdy),
        .busy     (busy),
        .grant    (grant)
    );

    always @(posedge clk_sys) cyc <= cyc + 1;

    // SDRAM model: mem_rdy on the rsp_delay-th cycle of mem_req; also logs rdy pulses.
    always @(negedge clk_sys) begin
        if (mem_req) begin
            rsp_cnt++;
            auto_rdy = (rsp_cnt == rsp_delay);
            mreq_total++;
        end else begin
            rsp_cnt  = 0;
            auto_rdy = 1'b0;
        end
        if (rdy != '0) begin
            rdy_log.push_back(rdy);
            rdy_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic wait_rdy(input int budget);
        int   b;
        int   base;
        logic ok;
        b    = 0;
        base = rdy_log.size();
        while (rdy_log.size() == base && b < budget) begin
            tick();
            b++;
        end
        ok = (rdy_log.size() > base);
        chk("rdy_wait", 64'(ok), 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int base;
        int mq0;
        logic [AW-1:0] b2b [3];
        logic [AW-1:0] caddr [4];
        logic [N-1:0]  exp_oh;
        int            exp_idx;

        reset_n  = 1'b0;
        req      = '0;
        req_addr = '0;
        mem_din  = '0;
        repeat (3) tick();
        chk("rst_rdy", 64'(rdy), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_mem_req", 64'(mem_req), 64'h0);
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        chk("rst_dout", dout, 64'h0);
        reset_n = 1'b1;
        tick();

        // Single request from requester 2, mem_rdy on the 5th mem_req cycle
        rsp_delay = 5;
        mem_din   = 64'hAAAA_AAAA_AAAA_AAAA;
        req_addr[2*AW +: AW] = 25'h12345;
        base = rdy_log.size();
        mq0  = mreq_total;
        c0   = cyc;
        req  = 4'b0100;
        tick();
        chk("single_mem_req", 64'(mem_req), 64'h1);
        chk("single_mem_addr", 64'(mem_addr), 64'h12345);
        chk("single_grant", 64'(grant), 64'h2);
        chk("single_busy", 64'(busy), 64'h1);
        wait_rdy(20);
        req = 4'b0000;
        chk("single_rdy", 64'(rdy), 64'h4);
        chk("single_dout", dout, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("single_latency", 64'(cyc - c0), 64'd6);
        chk("single_mreq_len", 64'(mreq_total - mq0), 64'd5);
        tick();
        chk("single_rdy_len", 64'(rdy), 64'h0);
        chk("single_idle_busy", 64'(busy), 64'h0);
        chk("single_addr_hold", 64'(mem_addr), 64'h12345);
        chk("single_count", 64'(rdy_log.size() - base), 64'd1);

        // Spurious mem_rdy in IDLE
        mem_din  = 64'h5555_5555_5555_5555;
        base     = rdy_log.size();
        spur_rdy = 1'b1;
        tick();
        spur_rdy = 1'b0;
        tick();
        chk("spur_dout", dout, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("spur_no_rdy", 64'(rdy_log.size() - base), 64'd0);
        chk("spur_busy", 64'(busy), 64'h0);

        // Back-to-back from requester 2 with a new address after each rdy
        rsp_delay = 1;
        b2b[0] = 25'h0000100;
        b2b[1] = 25'h0000104;
        b2b[2] = 25'h1FFFFFF;
        base = rdy_log.size();
        req_addr[2*AW +: AW] = b2b[0];
        mem_din = 64'hBB00_0000_0000_0000 | 64'(b2b[0]);
        req = 4'b0100;
        for (int j = 0; j < 3; j++) begin
            wait_rdy(10);
            chk("b2b_rdy", 64'(rdy), 64'h4);
            chk("b2b_addr", 64'(mem_addr), 64'(b2b[j]));
            chk("b2b_dout", dout, 64'hBB00_0000_0000_0000 | 64'(b2b[j]));
            if (j < 2) begin
                req_addr[2*AW +: AW] = b2b[j+1];
                mem_din = 64'hBB00_0000_0000_0000 | 64'(b2b[j+1]);
            end else begin
                req = 4'b0000;
            end
        end
        repeat (6) tick();
        chk("b2b_count", 64'(rdy_log.size() - base), 64'd3);
        chk("b2b_space01", 64'(rdy_cyc[base+1] - rdy_cyc[base]), 64'd3);
        chk("b2b_space12", 64'(rdy_cyc[base+2] - rdy_cyc[base+1]), 64'd3);

        // Requester 1 drops req during ISSUE; access still completes, then 3 is served
        rsp_delay = 4;
        mem_din = 64'h0000_0000_0000_00D1;
        req_addr[1*AW +: AW] = 25'h00AAA1;
        req_addr[3*AW +: AW] = 25'h00CCC3;
        req = 4'b1010;
        tick();
        chk("drop_grant", 64'(grant), 64'h1);
        chk("drop_mem_req", 64'(mem_req), 64'h1);
        chk("drop_addr", 64'(mem_addr), 64'h00AAA1);
        tick();
        req = 4'b1000;
        wait_rdy(10);
        chk("drop_rdy", 64'(rdy), 64'h2);
        chk("drop_dout", dout, 64'h0000_0000_0000_00D1);
        mem_din = 64'h0000_0000_0000_00D3;
        wait_rdy(10);
        req = 4'b0000;
        chk("drop_next_rdy", 64'(rdy), 64'h8);
        chk("drop_next_grant", 64'(grant), 64'h3);
        chk("drop_next_addr", 64'(mem_addr), 64'h00CCC3);
        chk("drop_next_dout", dout, 64'h0000_0000_0000_00D3);
        repeat (2) tick();

        // Asynchronous reset while in ISSUE
        rsp_delay = 20;
        req_addr[0*AW +: AW] = 25'h0000777;
        req_addr[1*AW +: AW] = 25'h000BEEF;
        req = 4'b0011;
        tick();
        tick();
        chk("ar_pre_mem_req", 64'(mem_req), 64'h1);
        chk("ar_pre_grant", 64'(grant), 64'h0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_mem_req", 64'(mem_req), 64'h0);
        chk("ar_busy", 64'(busy), 64'h0);
        chk("ar_rdy", 64'(rdy), 64'h0);
        chk("ar_mem_addr", 64'(mem_addr), 64'h0);
        chk("ar_dout", dout, 64'h0);
        repeat (2) tick();
        rsp_delay = 1;
        reset_n = 1'b1;
        tick();
        chk("ar_re_mem_req", 64'(mem_req), 64'h1);
        chk("ar_re_grant", 64'(grant), 64'h0);
        chk("ar_re_addr", 64'(mem_addr), 64'h0000777);
        wait_rdy(10);
        req = 4'b0010;
        chk("ar_re_rdy0", 64'(rdy), 64'h1);
        wait_rdy(10);
        req = 4'b0000;
        chk("ar_re_rdy1", 64'(rdy), 64'h2);
        chk("ar_re_addr1", 64'(mem_addr), 64'h000BEEF);
        repeat (3) tick();

        // Full contention: 22x req0, then 1,2,3 starved, 20x req0, then 1,2,3 again
        rsp_delay = 1;
        for (int i = 0; i < N; i++) begin
            caddr[i] = AW'(32'h0010000 * (i + 1));
            req_addr[i*AW +: AW] = caddr[i];
        end
        req = 4'b1111;
        for (int k = 0; k < 48; k++) begin
            case (k)
                22, 45:  exp_idx = 1;
                23, 46:  exp_idx = 2;
                24, 47:  exp_idx = 3;
                default: exp_idx = 0;
            endcase
            exp_oh = N'(1) << exp_idx;
            wait_rdy(10);
            if (k == 47) req = 4'b0000;
            chk($sformatf("cont_rdy_%0d", k), 64'(rdy), 64'(exp_oh));
            chk($sformatf("cont_addr_%0d", k), 64'(mem_addr), 64'(caddr[exp_idx]));
        end
        repeat (4) tick();
        chk("cont_idle", 64'(busy), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
